// File: rtl/lcd1602_bus_ctrl.sv
// lcd1602_bus_ctrl: HD44780/LCD1602 bus master that turns single-cycle CPU-side
// write/read strobes into complete E-cycles on the LCD header.
// Optional build macro LCD_BUSY_POLL_EN: after every write, poll the busy flag
// (D7) with read E-cycles instead of waiting a fixed T_EXEC clocks.
//
// Request handshake: wr_stb/rd_stb are one-cycle requests that are taken only
// while busy is low (controller in IDLE). busy rises the cycle after a request
// is taken and falls the cycle the controller re-enters IDLE, so a new request
// may be presented in that same cycle. A strobe seen while busy, or a read
// strobe that coincides with a taken write, is dropped and flagged by a
// one-cycle ovr pulse on the following cycle.
module lcd1602_bus_ctrl #(
  parameter int T_AS   = 2,
  parameter int T_PW   = 8,
  parameter int T_H    = 2,
  parameter int T_EXEC = 2000
) (
  input  logic       in_clock,
  input  logic       rst,
  input  logic       wr_stb,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  input  logic       rd_stb,
  input  logic       rd_rs,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy,
  output logic       ovr,
  output logic       lcd_e,
  output logic       lcd_rw,
  output logic       lcd_rs,
  output logic [7:0] lcd_d_out,
  output logic       lcd_d_oe,
  input  logic [7:0] lcd_d_in
);

  typedef enum logic [2:0] {
    IDLE, SETUP, EHIGH, HOLD, POLL_SETUP, POLL_EHIGH, POLL_HOLD, WAIT
  } state_t;

  // Timers hold "cycles remaining minus one", so a phase ends when they read 0.
  localparam logic [7:0]  AS_LOAD   = 8'(T_AS - 1);
  localparam logic [7:0]  PW_LOAD   = 8'(T_PW - 1);
  localparam logic [7:0]  H_LOAD    = 8'(T_H - 1);
  localparam logic [15:0] EXEC_LOAD = 16'(T_EXEC - 1);

  state_t      state, next_state;
  logic [7:0]  phase_cnt, phase_val;
  logic [15:0] wait_cnt;
  logic        phase_load, wait_load;
  logic        accept_wr, accept_rd, rd_done, wr_done, rd_sample_en;
  logic        is_rd;
  logic [7:0]  rd_sample;
`ifdef LCD_BUSY_POLL_EN
  logic        poll_sample_en;
  logic        poll_d7;
`endif

  // State register.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Next-state decode plus timer-load and event strobes for the datapath.
  always_comb begin
    next_state   = state;
    phase_load   = 1'b0;
    phase_val    = '0;
    wait_load    = 1'b0;
    accept_wr    = 1'b0;
    accept_rd    = 1'b0;
    rd_done      = 1'b0;
    wr_done      = 1'b0;
    rd_sample_en = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_sample_en = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (wr_stb) begin
          accept_wr  = 1'b1;
          next_state = SETUP;
          phase_load = 1'b1;
          phase_val  = AS_LOAD;
        end else if (rd_stb) begin
          accept_rd  = 1'b1;
          next_state = SETUP;
          phase_load = 1'b1;
          phase_val  = AS_LOAD;
        end
      end
      SETUP: if (phase_cnt == '0) begin
        next_state = EHIGH;
        phase_load = 1'b1;
        phase_val  = PW_LOAD;
      end
      EHIGH: if (phase_cnt == '0) begin
        rd_sample_en = is_rd;
        next_state   = HOLD;
        phase_load   = 1'b1;
        phase_val    = H_LOAD;
      end
      HOLD: if (phase_cnt == '0) begin
        if (is_rd) begin
          rd_done    = 1'b1;
          next_state = IDLE;
        end else begin
          wr_done = 1'b1;
`ifdef LCD_BUSY_POLL_EN
          next_state = POLL_SETUP;
          phase_load = 1'b1;
          phase_val  = AS_LOAD;
`else
          if (T_EXEC == 0) begin
            next_state = IDLE;
          end else begin
            next_state = WAIT;
            wait_load  = 1'b1;
          end
`endif
        end
      end
`ifdef LCD_BUSY_POLL_EN
      POLL_SETUP: if (phase_cnt == '0) begin
        next_state = POLL_EHIGH;
        phase_load = 1'b1;
        phase_val  = PW_LOAD;
      end
      POLL_EHIGH: if (phase_cnt == '0) begin
        poll_sample_en = 1'b1;
        next_state     = POLL_HOLD;
        phase_load     = 1'b1;
        phase_val      = H_LOAD;
      end
      POLL_HOLD: if (phase_cnt == '0) begin
        if (poll_d7) begin
          next_state = POLL_SETUP;
          phase_load = 1'b1;
          phase_val  = AS_LOAD;
        end else begin
          next_state = IDLE;
        end
      end
`endif
      WAIT: if (wait_cnt == '0) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Phase and post-write timers: load on entry, count down, stop at zero.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      phase_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (phase_load)          phase_cnt <= phase_val;
      else if (phase_cnt != 0) phase_cnt <= phase_cnt - 8'd1;
      if (wait_load)           wait_cnt  <= EXEC_LOAD;
      else if (wait_cnt != 0)  wait_cnt  <= wait_cnt - 16'd1;
    end
  end

  // Transaction type and LCD data samples taken on the last E-high cycle.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      is_rd     <= 1'b0;
      rd_sample <= '0;
`ifdef LCD_BUSY_POLL_EN
      poll_d7   <= 1'b0;
`endif
    end else begin
      if (accept_wr)    is_rd     <= 1'b0;
      if (accept_rd)    is_rd     <= 1'b1;
      if (rd_sample_en) rd_sample <= lcd_d_in;
`ifdef LCD_BUSY_POLL_EN
      if (poll_sample_en) poll_d7 <= lcd_d_in[7];
`endif
    end
  end

  // Registered LCD pins and CPU-side status; the bus is released when idle.
  always_ff @(posedge in_clock or negedge rst) begin
    if (!rst) begin
      lcd_e     <= 1'b0;
      lcd_rw    <= 1'b1;
      lcd_rs    <= 1'b0;
      lcd_d_out <= '0;
      lcd_d_oe  <= 1'b0;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      ovr       <= 1'b0;
    end else begin
      lcd_e    <= (next_state == EHIGH) || (next_state == POLL_EHIGH);
      busy     <= (next_state != IDLE);
      rd_valid <= rd_done;
      ovr      <= ((state != IDLE) && (wr_stb || rd_stb)) ||
                  ((state == IDLE) && wr_stb && rd_stb);
      if (rd_done) rd_data <= rd_sample;
      if (accept_wr) begin
        lcd_rw    <= 1'b0;
        lcd_rs    <= wr_rs;
        lcd_d_out <= wr_data;
        lcd_d_oe  <= 1'b1;
      end else if (accept_rd) begin
        lcd_rw   <= 1'b1;
        lcd_rs   <= rd_rs;
        lcd_d_oe <= 1'b0;
      end else if (wr_done) begin
        lcd_rw   <= 1'b1;
        lcd_d_oe <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
        lcd_rs   <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_lcd1602_bus_ctrl.sv
// tb_lcd1602_bus_ctrl: directed and randomized transactions on lcd1602_bus_ctrl,
// each measured cycle by cycle and compared with timing computed from the
// E-cycle rules. Honours LCD_BUSY_POLL_EN when the design is built with it.
module tb_lcd1602_bus_ctrl;

  localparam int T_AS   = 2;
  localparam int T_PW   = 8;
  localparam int T_H    = 2;
  localparam int T_EXEC = 2000;
  localparam int CYC    = T_AS + T_PW + T_H;

  logic       in_clock = 1'b0;
  logic       rst;
  logic       wr_stb, wr_rs, rd_stb, rd_rs;
  logic [7:0] wr_data;
  logic [7:0] rd_data;
  logic       rd_valid, busy, ovr;
  logic       lcd_e, lcd_rw, lcd_rs, lcd_d_oe;
  logic [7:0] lcd_d_out, lcd_d_in;

  // LCD model: presents lcd_byte while E is high, its complement otherwise.
  logic [7:0] lcd_byte;
  assign lcd_d_in = lcd_e ? lcd_byte : ~lcd_byte;

  int         checks = 0;
  int         failures = 0;
  int         poll_busy_n = 0;
  logic [7:0] last_rd = 8'h00;

  // Clock block.
  always #5 in_clock = ~in_clock;

  lcd1602_bus_ctrl #(.T_AS(T_AS), .T_PW(T_PW), .T_H(T_H), .T_EXEC(T_EXEC)) dut (
    .in_clock (in_clock),
    .rst      (rst),
    .wr_stb   (wr_stb),
    .wr_rs    (wr_rs),
    .wr_data  (wr_data),
    .rd_stb   (rd_stb),
    .rd_rs    (rd_rs),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .busy     (busy),
    .ovr      (ovr),
    .lcd_e    (lcd_e),
    .lcd_rw   (lcd_rw),
    .lcd_rs   (lcd_rs),
    .lcd_d_out(lcd_d_out),
    .lcd_d_oe (lcd_d_oe),
    .lcd_d_in (lcd_d_in)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge in_clock);
    #1;
  endtask

  // One transaction: drive the strobe, watch every cycle until busy drops,
  // then compare the measured shape with the expected one.
  // both: also raise rd_stb alongside a write. inject_at: sample index at which
  // a second wr_stb is offered while busy (-1 = none).
  task automatic run_txn(input logic is_wr, input logic both, input logic rs,
                         input logic [7:0] data, input int inject_at);
    int exp_total, exp_rises, budget;
    int e_first, e_rises, e_cnt, rv_cnt, rv_at, busy_cnt, ovr_cnt, idle_at;
    logic prev_e, bus_ok;
    logic [7:0] rv_data;
`ifdef LCD_BUSY_POLL_EN
    exp_total = is_wr ? CYC * (2 + poll_busy_n) : CYC;
    exp_rises = is_wr ? 2 + poll_busy_n : 1;
`else
    exp_total = is_wr ? CYC + T_EXEC : CYC;
    exp_rises = 1;
`endif
    budget  = exp_total + 50;
    e_first = -1; e_rises = 0; e_cnt = 0; rv_cnt = 0; rv_at = -1;
    busy_cnt = 0; ovr_cnt = 0; idle_at = -1; prev_e = 1'b0; bus_ok = 1'b1;
    rv_data = 8'h00;
    lcd_byte = is_wr ? 8'h80 : data;
    if (is_wr) begin
      wr_stb = 1'b1; wr_rs = rs; wr_data = data;
      rd_stb = both; rd_rs = ~rs;
    end else begin
      rd_stb = 1'b1; rd_rs = rs;
    end
    step();
    wr_stb = 1'b0; rd_stb = 1'b0;
    wr_data = 8'($urandom); wr_rs = 1'($urandom); rd_rs = 1'($urandom);
    for (int s = 0; s < budget; s++) begin
      if (lcd_e && !prev_e) begin
        e_rises++;
        if (e_first < 0) e_first = s;
      end
      prev_e = lcd_e;
      if (lcd_e) begin
        if (e_rises == 1) begin
          e_cnt++;
          if (lcd_rw !== ~is_wr || lcd_rs !== rs || lcd_d_oe !== is_wr) bus_ok = 1'b0;
          if (is_wr && lcd_d_out !== data) bus_ok = 1'b0;
        end else if (lcd_rw !== 1'b1 || lcd_rs !== 1'b0 || lcd_d_oe !== 1'b0) begin
          bus_ok = 1'b0;
        end
      end else if (is_wr) begin
        lcd_byte = (e_rises - 1 < poll_busy_n) ? 8'h80 : 8'h00;
      end
      if (!is_wr && lcd_d_oe !== 1'b0) bus_ok = 1'b0;
      if (rd_valid) begin rv_cnt++; rv_at = s; rv_data = rd_data; end
      if (ovr) ovr_cnt++;
      if (!busy) begin idle_at = s; break; end
      busy_cnt++;
      wr_stb = (s == inject_at);
      step();
    end
    wr_stb = 1'b0;
    check("e_start", e_first, T_AS);
    check("e_width", e_cnt, T_PW);
    check("e_pulses", e_rises, exp_rises);
    check("busy_len", busy_cnt, exp_total);
    check("idle_at", idle_at, exp_total);
    check("bus_fields", bus_ok, 1);
    check("idle_bus", {lcd_rw, lcd_d_oe}, 2'b10);
    check("ovr_count", ovr_cnt, 32'(both) + ((inject_at >= 0) ? 1 : 0));
    check("rd_valid_count", rv_cnt, is_wr ? 0 : 1);
    if (!is_wr) begin
      check("rd_valid_at", rv_at, CYC);
      check("rd_data", rv_data, data);
      last_rd = data;
    end else begin
      check("rd_data_held", rd_data, last_rd);
    end
  endtask

  // Directed and randomized sequence, then the summary.
  initial begin
    int rv_cnt, busy_cnt, e_cnt;
    rst = 1'b0; wr_stb = 1'b0; wr_rs = 1'b0; wr_data = 8'h00;
    rd_stb = 1'b0; rd_rs = 1'b0; lcd_byte = 8'h00;
    repeat (3) step();
    rst = 1'b1;
    repeat (10) step();
    check("rst_lcd_e", lcd_e, 0);
    check("rst_lcd_rw", lcd_rw, 1);
    check("rst_lcd_rs", lcd_rs, 0);
    check("rst_lcd_d_oe", lcd_d_oe, 0);
    check("rst_lcd_d_out", lcd_d_out, 0);
    check("rst_busy", busy, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_ovr", ovr, 0);

    poll_busy_n = 3;
    run_txn(1'b1, 1'b0, 1'b1, 8'h41, -1);
    run_txn(1'b0, 1'b0, 1'b1, 8'h5A, -1);
    poll_busy_n = 1;
    run_txn(1'b1, 1'b1, 1'b0, 8'h38, 3);

    for (int i = 0; i < 10; i++) begin
      run_txn(1'b0, 1'b0, 1'($urandom), 8'($urandom),
              ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, CYC - 3)) : -1);
    end
    poll_busy_n = int'($urandom_range(0, 2));
    run_txn(1'b1, 1'($urandom), 1'($urandom), 8'($urandom), -1);

    // Reset while E is high on its fifth cycle.
    lcd_byte = 8'hC3;
    rd_stb = 1'b1; rd_rs = 1'b0;
    step();
    rd_stb = 1'b0;
    repeat (T_AS + 4) step();
    check("pre_rst_lcd_e", lcd_e, 1);
    #2 rst = 1'b0;
    #1;
    check("async_rst_lcd_e", lcd_e, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) step();
    rst = 1'b1;
    rv_cnt = 0; busy_cnt = 0; e_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (rd_valid) rv_cnt++;
      if (busy) busy_cnt++;
      if (lcd_e) e_cnt++;
      step();
    end
    check("post_rst_rd_valid", rv_cnt, 0);
    check("post_rst_busy", busy_cnt, 0);
    check("post_rst_lcd_e", e_cnt, 0);
    check("post_rst_rd_data", rd_data, 0);
    last_rd = 8'h00;
    run_txn(1'b0, 1'b0, 1'b0, 8'h7E, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcd1602_bus_ctrl.md
Name: lcd1602_bus_ctrl

Overview:
- Hardware HD44780/LCD1602 bus master. Replaces the CPU bit-banging of lcd_e/lcd_rw/lcd_rs.
- The Z80 IO glue issues a single-cycle write or read request. The block generates the full E-cycle timing.
- Reads capture the LCD data bus and return it to the CPU side.
- Keeps busy asserted until the LCD can accept the next access. Sits between the IO decode and the LCD1602 header.

Parameters:
- T_AS, 2: clocks from RS/RW/data valid to E rise (address setup); 1..255.
- T_PW, 8: clocks E held high; 1..255.
- T_H, 2: clocks after E fall before the bus is released or the next phase starts; 1..255.
- T_EXEC, 2000: fixed post-write wait in clocks when busy polling is compiled out; 0..65535.

Ports:
- in_clock  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous active-low reset
- wr_stb  input  1  one-cycle write request, already synchronous to in_clock
- wr_rs  input  1  RS for write (0 = command, 1 = data)
- wr_data  input  8  byte to write
- rd_stb  input  1  one-cycle read request
- rd_rs  input  1  RS for read (0 = BF/address, 1 = DDRAM/CGRAM data)
- rd_data  output  8  last byte read, held until the next read completes
- rd_valid  output  1  one-cycle pulse when rd_data updates
- busy  output  1  high from the accepting cycle until the controller is back in IDLE
- ovr  output  1  one-cycle pulse when a request arrives while busy (request dropped)
- lcd_e  output  1  LCD enable
- lcd_rw  output  1  LCD R/W (1 = read)
- lcd_rs  output  1  LCD RS
- lcd_d_out  output  8  data driven to LCD
- lcd_d_oe  output  1  1 = drive lcd_d_out onto the LCD bus
- lcd_d_in  input  8  LCD data bus sampled value

Behaviour:
- Reset (rst low, async): state IDLE. All timers 0. Outputs: lcd_e=0, lcd_rw=1, lcd_rs=0, lcd_d_oe=0, lcd_d_out=0, rd_data=0, rd_valid=0, busy=0, ovr=0. Asserting rst mid-cycle drops lcd_e immediately; no completion pulses.
- States: IDLE, SETUP, EHIGH, HOLD, POLL_SETUP, POLL_EHIGH, POLL_HOLD, WAIT.
- Idle bus: lcd_rw=1, lcd_d_oe=0 (never contend with the LCD).
- Accept in IDLE only:
  - wr_stb: latch wr_rs/wr_data; lcd_rw=0, lcd_rs=wr_rs, lcd_d_out=wr_data, lcd_d_oe=1; busy=1 next cycle; go to SETUP.
  - rd_stb: latch rd_rs; lcd_rw=1, lcd_rs=rd_rs, lcd_d_oe=0; go to SETUP.
  - wr_stb and rd_stb in the same cycle: write accepted, read dropped, ovr pulses.
- Any stb while busy=1: ignored; ovr=1 for that cycle; no state change.
- SETUP: T_AS cycles, lcd_e=0 → EHIGH.
- EHIGH: lcd_e=1 for exactly T_PW cycles. On a read, sample lcd_d_in on the last EHIGH cycle → HOLD.
- HOLD: lcd_e=0, T_H cycles, RS/RW/data held stable.
  - Read exit: rd_data=sample, rd_valid=1 for one cycle, → IDLE.
  - Write exit: lcd_d_oe=0, lcd_rw=1, → POLL_SETUP (feature on) or WAIT (feature off).
- Write E-cycle length: T_AS+T_PW+T_H clocks from acceptance to end of HOLD.
- busy deasserts the same cycle the state enters IDLE. A new request is accepted in that first IDLE cycle.
- Timers: 8-bit phase counter, 16-bit WAIT counter. Both load on entry and count down to 0. No wrap; a parameter value of 0 for T_EXEC skips WAIT.

Optional Feature:
- Macro: LCD_BUSY_POLL_EN.
- Defined: after each write, repeat read E-cycles with rs=0, rw=1 (POLL_SETUP/POLL_EHIGH/POLL_HOLD, same T_AS/T_PW/T_H). Sample D7 on the last POLL_EHIGH cycle.
  - D7=1: loop again.
  - D7=0: → IDLE after POLL_HOLD.
  - Poll results do not touch rd_data and do not pulse rd_valid.
  - No timeout; reset is the only escape.
- Undefined: post-write goes to WAIT for T_EXEC clocks, then IDLE. The POLL states and the lcd_d_in path in write mode are not built.

Test Plan:
- Reset release, then idle 10 clocks → lcd_e=0, lcd_rw=1, lcd_d_oe=0, busy=0, rd_data=0.
- Write, feature off: wr_stb with rs=1, data=0x41 → lcd_rs=1, lcd_rw=0, lcd_d_out=0x41, oe=1. lcd_e high exactly 8 clocks starting 2 clocks after acceptance. busy lasts 12+2000 clocks.
- Read: rd_stb with rs=1, LCD model drives 0x5A during E → rd_valid pulses once, 12 clocks after acceptance, with rd_data=0x5A. lcd_d_oe stays 0 throughout.
- Collisions:
  - wr_stb+rd_stb in the same cycle → only the write runs; ovr pulses once.
  - wr_stb again 3 clocks later (busy) → ovr pulses, no second E pulse.
- Reset mid-EHIGH: rst low at clock 5 of E high → lcd_e=0 asynchronously; after release busy=0, no rd_valid pulse.
- LCD_BUSY_POLL_EN: model returns D7=1 for 3 polls, then 0x00 → exactly 4 poll E pulses with rw=1, rs=0; busy drops after the 4th POLL_HOLD; rd_valid never pulses.
